// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory.
// Contents: default geometry, FSM state type, NOP word and byte-address helpers.
package imem_pkg;

  localparam int unsigned ImemInstrW   = 32;
  localparam int unsigned ImemAddrW    = 32;
  localparam int unsigned ImemDepth    = 1024;
  // Addresses are widened to this before range checks so no upper bit is ever dropped.
  localparam int unsigned ImemMaxAddrW = 64;

  localparam logic [ImemInstrW-1:0] IMEM_NOP = '0;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } imem_state_e;

  typedef logic [ImemMaxAddrW-1:0] imem_wide_addr_t;

  // Word index of a byte address; kept full width so callers can range-check it.
  function automatic imem_wide_addr_t word_idx(input imem_wide_addr_t addr);
    return addr >> 2;
  endfunction

  function automatic logic byte_misaligned(input imem_wide_addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch / program bus of the instruction memory.
// slave  : memory side (instr_fetch_mem)
// master : fetch stage / program loader side
// Signals: fetch_req, fetch_pc, fetch_ready, instr_valid, instr_ready, instruction, fault,
//          parity_err, prog_we, prog_addr, prog_data, busy.
interface instr_fetch_mem_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32
);

  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               fetch_ready;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic               fault;
  logic               parity_err;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               busy;

  modport slave (
    input  fetch_req, fetch_pc, instr_ready, prog_we, prog_addr, prog_data,
    output fetch_ready, instr_valid, instruction, fault, parity_err, busy
  );

  modport master (
    output fetch_req, fetch_pc, instr_ready, prog_we, prog_addr, prog_data,
    input  fetch_ready, instr_valid, instruction, fault, parity_err, busy
  );

endinterface

// File: rtl/imem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on the array.
// Same-address write and read in one cycle returns the old contents.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read enable/address),
//        rdata_o (read data register, holds when re_i is low).
module imem_sdp_ram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with fetch valid/ready handshake and program-load port.
// After reset every word is cleared (one word per cycle, busy high), then fetches are served
// with one cycle latency through a single output register.
// Ports: clk, rst_n (synchronous, active low), bus (instr_fetch_mem_if.slave).
// Optional: define IMEM_PARITY_EN to store an even-parity bit per word and report mismatches
// on parity_err; otherwise parity_err is tied low.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int unsigned INSTR_W = ImemInstrW,
  parameter int unsigned ADDR_W  = ImemAddrW,
  parameter int unsigned DEPTH   = ImemDepth
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_mem_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int unsigned RamW = INSTR_W + 1;
`else
  localparam int unsigned RamW = INSTR_W;
`endif

  imem_state_e     state_q;
  logic [IdxW-1:0] clr_idx_q;
  logic            valid_q;
  logic            fault_q;
  // Output shows RAM data only after a good read; reset and faulted fetches show NOP.
  logic            rd_sel_q;

  imem_wide_addr_t fetch_wide, prog_wide;
  imem_wide_addr_t fetch_widx, prog_widx;
  logic            fetch_fault;
  logic            prog_ok;
  logic            fetch_ready;
  logic            fetch_accept;

  logic            ram_we;
  logic [IdxW-1:0] ram_waddr;
  logic [RamW-1:0] ram_wdata;
  logic [RamW-1:0] prog_word;
  logic            ram_re;
  logic [RamW-1:0] ram_rdata;

  assign fetch_wide = imem_wide_addr_t'(bus.fetch_pc);
  assign prog_wide  = imem_wide_addr_t'(bus.prog_addr);
  assign fetch_widx = word_idx(fetch_wide);
  assign prog_widx  = word_idx(prog_wide);

  // Full-width compare: an address above the array never aliases onto a low word.
  assign fetch_fault = byte_misaligned(fetch_wide) || (fetch_widx >= imem_wide_addr_t'(DEPTH));
  assign prog_ok     = !byte_misaligned(prog_wide) && (prog_widx < imem_wide_addr_t'(DEPTH));

  // Single output register: accept whenever it is empty or being drained this cycle.
  assign fetch_ready  = (state_q == StRun) && (!valid_q || bus.instr_ready);
  assign fetch_accept = bus.fetch_req && fetch_ready;
  assign ram_re       = fetch_accept && !fetch_fault;

`ifdef IMEM_PARITY_EN
  assign prog_word = {^bus.prog_data, bus.prog_data};
`else
  assign prog_word = bus.prog_data;
`endif

  // Write port owned by the clear sequence until RUN, then by the program port.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_idx_q;
    ram_wdata = '0;
    if (state_q == StClear) begin
      ram_we = 1'b1;
    end else if (bus.prog_we && prog_ok) begin
      ram_we    = 1'b1;
      ram_waddr = prog_widx[IdxW-1:0];
      ram_wdata = prog_word;
    end
  end

  imem_sdp_ram #(
    .Width(RamW),
    .Depth(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(fetch_widx[IdxW-1:0]),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_idx_q <= clr_idx_q + IdxW'(1);
          if (clr_idx_q == IdxW'(DEPTH - 1)) begin
            state_q <= StRun;
          end
        end
        StRun: state_q <= StRun;
      endcase

      if (fetch_accept) begin
        valid_q  <= 1'b1;
        fault_q  <= fetch_fault;
        rd_sel_q <= !fetch_fault;
      end else if (bus.instr_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.busy        = (state_q == StClear);
  assign bus.instruction = rd_sel_q ? ram_rdata[INSTR_W-1:0] : INSTR_W'(IMEM_NOP);

`ifdef IMEM_PARITY_EN
  assign bus.parity_err = rd_sel_q && ((^ram_rdata[INSTR_W-1:0]) != ram_rdata[INSTR_W]);
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed scenarios plus random traffic. A predictor pushes the
// expected response of every accepted fetch; a monitor pops and compares on the output side.
module tb_instr_fetch_mem;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned IdxW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_mem_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

  instr_fetch_mem #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [INSTR_W-1:0] data;
    logic               fault;
    logic               perr;
    int unsigned        acc;
    bit                 seen;
  } exp_t;

  exp_t               exp_q[$];
  logic [INSTR_W-1:0] mdl [DEPTH];
  bit                 pbad [DEPTH];
  int unsigned        cyc = 0;
  int unsigned        clr_cnt = 0;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic logic [IdxW-1:0] widx(input logic [ADDR_W-1:0] a);
    return IdxW'(a / 4);
  endfunction

  // Cycle count and cycles elapsed since reset release (memory busy for the first DEPTH).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) clr_cnt <= 0;
    else if (clr_cnt < DEPTH) clr_cnt <= clr_cnt + 1;
  end

  // Predictor: memory model as a plain array, updated after the read (old data on collision).
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      foreach (mdl[i]) begin
        mdl[i]  = '0;
        pbad[i] = 1'b0;
      end
    end else if (clr_cnt >= DEPTH) begin
      if (bus.fetch_req && bus.fetch_ready) begin
        e.fault = !addr_ok(bus.fetch_pc);
        e.data  = e.fault ? '0 : mdl[widx(bus.fetch_pc)];
        e.perr  = !e.fault && pbad[widx(bus.fetch_pc)];
        e.acc   = cyc;
        e.seen  = 1'b0;
        exp_q.push_back(e);
      end
      if (bus.prog_we && addr_ok(bus.prog_addr)) begin
        mdl[widx(bus.prog_addr)]  = bus.prog_data;
        pbad[widx(bus.prog_addr)] = 1'b0;
      end
    end
  end

  // Monitor: handshake outputs every cycle, response data against the queue head.
  always @(negedge clk) begin
    bit busy_exp;
    if (rst_n) begin
      busy_exp = (clr_cnt < DEPTH);
      chk("busy", bus.busy, busy_exp);
      chk("fetch_ready", bus.fetch_ready, !busy_exp && (!bus.instr_valid || bus.instr_ready));
      if (bus.instr_valid) begin
        if (exp_q.size() == 0 || exp_q[0].acc >= cyc) begin
          chk("no_spurious_valid", bus.instr_valid, 1'b0);
        end else begin
          chk("instruction", bus.instruction, exp_q[0].data);
          chk("fault", bus.fault, exp_q[0].fault);
          chk("parity_err", bus.parity_err, exp_q[0].perr);
          if (!exp_q[0].seen) begin
            chk("latency", cyc, exp_q[0].acc + 1);
            exp_q[0].seen = 1'b1;
          end
          if (bus.instr_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && exp_q[0].acc < cyc) begin
        chk("instr_valid", bus.instr_valid, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic fetch_one(input logic [ADDR_W-1:0] pc);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    tick();
    bus.fetch_req = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int unsigned cnt = 0;
    while (bus.busy === 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
    chk(name, cnt, DEPTH);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int unsigned s;
    s = $urandom_range(0, 9);
    if (s < 7) return $urandom_range(0, 47) * 4;
    else if (s == 7) return ($urandom_range(0, 47) * 4) | $urandom_range(1, 3);
    else return 32'h1000 + ($urandom & 32'h7FFF_FFFC);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.fetch_req   = 1'b1;
    bus.fetch_pc    = 32'h40;
    bus.instr_ready = 1'b1;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    repeat (3) tick();
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_instruction", bus.instruction, 32'h0);
    chk("rst_fault", bus.fault, 1'b0);
    chk("rst_parity_err", bus.parity_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_fetch_ready", bus.fetch_ready, 1'b0);

    // Clear length with fetch_req held high, then first fetch of a cleared word.
    rst_n = 1'b1;
    wait_clear("clear_cycles");
    tick();
    bus.fetch_req = 1'b0;
    tick();

    // Program two words and fetch them back to back.
    prog_write(32'h0, 32'hF840_0281);
    prog_write(32'h4, 32'h8B01_0022);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0;
    tick();
    bus.fetch_pc = 32'h4;
    tick();
    bus.fetch_req = 1'b0;
    tick();

    // Faulting and boundary addresses.
    fetch_one(32'h2);
    fetch_one(32'h1000);
    fetch_one(32'hFFC);
    fetch_one(32'h8000_0000);
    tick();

    // Stall for five cycles, then the next request goes in on the release cycle.
    bus.instr_ready = 1'b0;
    bus.fetch_req   = 1'b1;
    bus.fetch_pc    = 32'h0;
    tick();
    bus.fetch_pc = 32'h4;
    repeat (5) begin
      chk("stall_fetch_ready", bus.fetch_ready, 1'b0);
      tick();
    end
    bus.instr_ready = 1'b1;
    #1;
    chk("release_fetch_ready", bus.fetch_ready, 1'b1);
    tick();
    bus.fetch_req = 1'b0;
    repeat (2) tick();

    // Same-cycle write and fetch returns old data; refetch returns new data.
    bus.prog_we   = 1'b1;
    bus.prog_addr = 32'h28;
    bus.prog_data = 32'h9100_2294;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h28;
    tick();
    bus.prog_we = 1'b0;
    tick();
    bus.fetch_req = 1'b0;
    tick();

    // Misaligned and out-of-range writes must not land anywhere.
    prog_write(32'h2A, 32'hDEAD_BEEF);
    prog_write(32'h1000, 32'h0BAD_F00D);
    prog_write(32'h8000_0028, 32'h1357_9BDF);
    fetch_one(32'h28);
    fetch_one(32'h0);
    tick();

`ifdef IMEM_PARITY_EN
    prog_write(32'hC, 32'h1234_5671);
    tick();
    u_dut.u_ram.mem_q[3][INSTR_W] = ~u_dut.u_ram.mem_q[3][INSTR_W];
    pbad[3] = 1'b1;
    fetch_one(32'hC);
    fetch_one(32'h8);
    prog_write(32'hC, 32'h0000_0003);
    fetch_one(32'hC);
    tick();
`endif

    // Reset in the middle of a clear restarts it from word 0.
    prog_write(32'h14, 32'h5A5A_1234);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h14;
    rst_n         = 1'b1;
    wait_clear("clear_restart_cycles");
    tick();
    bus.fetch_req = 1'b0;
    tick();

    // Random traffic.
    repeat (800) begin
      bus.fetch_req   = ($urandom_range(0, 9) < 7);
      bus.fetch_pc    = rand_addr();
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.prog_we     = ($urandom_range(0, 9) < 3);
      bus.prog_addr   = rand_addr();
      bus.prog_data   = $urandom;
      tick();
    end

    bus.fetch_req   = 1'b0;
    bus.prog_we     = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
